// File: rtl/hit_damage_tracker.sv
// Per-frame hit sampling, health/invulnerability bookkeeping, stun pulses and
// the PLAY / KO / OVER round state machine for a two-player fighter.
module hit_damage_tracker #(
  parameter int unsigned HEALTH_MAX     = 10,
  parameter int unsigned BASIC_DMG      = 1,
  parameter int unsigned DIR_DMG        = 2,
  parameter int unsigned INVULN_FRAMES  = 16,
  parameter int unsigned KO_HOLD_FRAMES = 120
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       frame_tick,
  input  logic [1:0] p1_hit_flag,
  input  logic [1:0] p2_hit_flag,
  input  logic       new_round,
  output logic [3:0] p1_health,
  output logic [3:0] p2_health,
  output logic       p1_stun_req,
  output logic       p2_stun_req,
  output logic [1:0] p1_stun_type,
  output logic [1:0] p2_stun_type,
  output logic [1:0] game_state,
  output logic [1:0] winner,
  output logic       freeze
);

  localparam int unsigned HW = 4;
  localparam int unsigned IW = 6;
  localparam int unsigned KW = 8;
  localparam int unsigned FW = 2;

  typedef enum logic [1:0] {
    ST_PLAY = 2'b00,
    ST_KO   = 2'b01,
    ST_OVER = 2'b10
  } state_e;

  state_e                   state_q, state_d;
  logic [KW-1:0]            ko_cnt_q, ko_cnt_d;
  logic [1:0][HW-1:0]       health_q, health_d;
  logic [1:0][IW-1:0]       invuln_q, invuln_d;
  logic [1:0]               stun_q, stun_d;
  logic [1:0][FW-1:0]       stype_q, stype_d;
  logic [1:0]               winner_q, winner_d;
  logic                     freeze_q, freeze_d;
  logic [1:0][FW-1:0]       flag_c;
  logic [1:0]               accept_c;
  logic                     ko_entry_c;

  assign flag_c[0] = p1_hit_flag;
  assign flag_c[1] = p2_hit_flag;

  // Health minus the damage for this hit type, clamped at zero.
  function automatic logic [HW-1:0] sat_sub(input logic [HW-1:0] h, input logic [FW-1:0] f);
    int unsigned d;
    d = (f == 2'b01) ? BASIC_DMG : DIR_DMG;
    if (32'(h) > d) return h - HW'(d);
    return '0;
  endfunction

  // State register and all output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_PLAY;
      ko_cnt_q <= '0;
      health_q <= {2{HW'(HEALTH_MAX)}};
      invuln_q <= '0;
      stun_q   <= '0;
      stype_q  <= '0;
      winner_q <= '0;
      freeze_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      ko_cnt_q <= ko_cnt_d;
      health_q <= health_d;
      invuln_q <= invuln_d;
      stun_q   <= stun_d;
      stype_q  <= stype_d;
      winner_q <= winner_d;
      freeze_q <= freeze_d;
    end
  end

  // Next-state logic: KO entry comes from post-damage health.
  always_comb begin
    state_d  = state_q;
    ko_cnt_d = ko_cnt_q;
    case (state_q)
      ST_PLAY: begin
        if (ko_entry_c) begin
          state_d  = ST_KO;
          ko_cnt_d = KW'(KO_HOLD_FRAMES);
        end
      end
      ST_KO: begin
        if (frame_tick) begin
          if (ko_cnt_q == KW'(1)) state_d = ST_OVER;
          else ko_cnt_d = ko_cnt_q - KW'(1);
        end
      end
      ST_OVER: begin
        if (new_round) begin
          state_d  = ST_PLAY;
          ko_cnt_d = '0;
        end
      end
      default: state_d = ST_PLAY;
    endcase
  end

  // Output logic: hit acceptance, damage, invulnerability and round restart.
  always_comb begin
    health_d   = health_q;
    invuln_d   = invuln_q;
    stun_d     = '0;
    stype_d    = stype_q;
    winner_d   = winner_q;
    freeze_d   = freeze_q;
    accept_c   = '0;
    ko_entry_c = 1'b0;

    for (int i = 0; i < 2; i++) begin
      accept_c[i] = frame_tick && (state_q == ST_PLAY) &&
                    ((flag_c[i] == 2'b01) || (flag_c[i] == 2'b10)) &&
                    (invuln_q[i] == '0);
      if (accept_c[i]) begin
        health_d[i] = sat_sub(health_q[i], flag_c[i]);
        invuln_d[i] = IW'(INVULN_FRAMES);
        stun_d[i]   = 1'b1;
        stype_d[i]  = flag_c[i];
      end else if (frame_tick && (invuln_q[i] != '0)) begin
        invuln_d[i] = invuln_q[i] - IW'(1);
      end
    end

    if (frame_tick && (state_q == ST_PLAY) &&
        ((health_d[0] == '0) || (health_d[1] == '0))) begin
      ko_entry_c = 1'b1;
      // Bit 1 set when P1 fell (P2 wins), bit 0 when P2 fell; both = draw.
      winner_d   = {health_d[0] == '0, health_d[1] == '0};
      freeze_d   = 1'b1;
    end

    if ((state_q == ST_OVER) && new_round) begin
      health_d = {2{HW'(HEALTH_MAX)}};
      invuln_d = '0;
      stype_d  = '0;
      winner_d = '0;
      freeze_d = 1'b0;
    end
  end

  assign p1_health    = health_q[0];
  assign p2_health    = health_q[1];
  assign p1_stun_req  = stun_q[0];
  assign p2_stun_req  = stun_q[1];
  assign p1_stun_type = stype_q[0];
  assign p2_stun_type = stype_q[1];
  assign game_state   = state_q;
  assign winner       = winner_q;
  assign freeze       = freeze_q;

endmodule

// File: tb/tb_hit_damage_tracker.sv
// Scoreboard bench for hit_damage_tracker: stimulus queues the expected output
// snapshot for the cycle after each edge, a monitor pops and compares it.
module tb_hit_damage_tracker;

  typedef struct packed {
    logic [3:0] h1;
    logic [3:0] h2;
    logic       s1;
    logic       s2;
    logic [1:0] t1;
    logic [1:0] t2;
    logic [1:0] gs;
    logic [1:0] win;
    logic       frz;
  } snap_t;

  logic       clk;
  logic       rst;
  logic       frame_tick;
  logic [1:0] p1_hit_flag;
  logic [1:0] p2_hit_flag;
  logic       new_round;
  logic [3:0] p1_health, p2_health;
  logic       p1_stun_req, p2_stun_req;
  logic [1:0] p1_stun_type, p2_stun_type;
  logic [1:0] game_state, winner;
  logic       freeze;

  hit_damage_tracker dut (
    .clk          (clk),
    .rst          (rst),
    .frame_tick   (frame_tick),
    .p1_hit_flag  (p1_hit_flag),
    .p2_hit_flag  (p2_hit_flag),
    .new_round    (new_round),
    .p1_health    (p1_health),
    .p2_health    (p2_health),
    .p1_stun_req  (p1_stun_req),
    .p2_stun_req  (p2_stun_req),
    .p1_stun_type (p1_stun_type),
    .p2_stun_type (p2_stun_type),
    .game_state   (game_state),
    .winner       (winner),
    .freeze       (freeze)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int    cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  snap_t exp_q[$];
  int    due_q[$];
  string name_q[$];
  snap_t e;
  int    errors = 0;
  int    checks = 0;
  logic  done = 1'b0;

  // Drive one cycle of inputs and queue the snapshot expected after its edge.
  task automatic step(input logic tk, input logic [1:0] a, input logic [1:0] b,
                      input logic nr, input logic r, input string nm);
    frame_tick  = tk;
    p1_hit_flag = a;
    p2_hit_flag = b;
    new_round   = nr;
    rst         = r;
    exp_q.push_back(e);
    due_q.push_back(cyc + 1);
    name_q.push_back(nm);
    @(negedge clk);
  endtask

  task automatic reset_exp();
    e = '{h1: 4'd10, h2: 4'd10, s1: 1'b0, s2: 1'b0, t1: 2'b00, t2: 2'b00,
          gs: 2'b00, win: 2'b00, frz: 1'b0};
  endtask

  // Stimulus
  initial begin
    logic [1:0] f;
    rst = 1'b1; frame_tick = 1'b0; p1_hit_flag = 2'b00; p2_hit_flag = 2'b00; new_round = 1'b0;
    reset_exp();
    @(negedge clk);
    step(0, 2'b00, 2'b00, 0, 1, "reset0");
    step(0, 2'b00, 2'b00, 0, 1, "reset1");

    // Single basic hit on P2.
    e.h2 = 4'd9; e.s2 = 1'b1; e.t2 = 2'b01;
    step(1, 2'b00, 2'b01, 0, 0, "p2_basic_hit");
    e.s2 = 1'b0;
    step(0, 2'b00, 2'b00, 0, 0, "p2_basic_pulse_end");

    // P1 directional flag held 40 ticks: accepted at 0, 17, 34.
    for (int i = 0; i < 40; i++) begin
      if (i % 17 == 0) begin
        e.h1 = e.h1 - 4'd2; e.s1 = 1'b1; e.t1 = 2'b10;
      end
      step(1, 2'b10, 2'b00, 0, 0, "p1_hold_tick");
      e.s1 = 1'b0;
      step(0, 2'b10, 2'b00, 0, 0, "p1_hold_gap");
    end

    // Flags without frame_tick change nothing.
    for (int i = 0; i < 100; i++) step(0, 2'b01, 2'b10, 0, 0, "no_tick");
    // Flag 11 is never accepted.
    for (int i = 0; i < 20; i++) step(1, 2'b11, 2'b11, 0, 0, "flag11_tick");

    // P2 directional hits down to zero (1 - 2 saturates), then KO with P1 winning.
    for (int i = 0; i <= 68; i++) begin
      if (i % 17 == 0) begin
        e.h2 = (e.h2 > 4'd2) ? e.h2 - 4'd2 : 4'd0;
        e.s2 = 1'b1; e.t2 = 2'b10;
      end
      if (i == 68) begin
        e.gs = 2'b01; e.win = 2'b01; e.frz = 1'b1;
      end
      step(1, 2'b00, 2'b10, 0, 0, "p2_ko_run_tick");
      e.s2 = 1'b0;
      step(0, 2'b00, 2'b10, 0, 0, "p2_ko_run_gap");
    end

    // KO hold: hits and new_round ignored; OVER after the 120th tick.
    for (int k = 1; k <= 120; k++) begin
      if (k == 120) e.gs = 2'b10;
      step(1, 2'b01, 2'b10, 0, 0, "ko_hold_tick");
      step(0, 2'b01, 2'b10, (k < 120), 0, "ko_hold_newround");
    end
    for (int k = 0; k < 5; k++) step(1, 2'b01, 2'b01, 0, 0, "over_hold");

    reset_exp();
    step(0, 2'b00, 2'b00, 1, 0, "over_new_round");
    step(0, 2'b00, 2'b00, 0, 0, "after_new_round");

    // Both players worn down to 1, then a simultaneous basic hit: draw.
    for (int i = 0; i <= 85; i++) begin
      f = (i < 68) ? 2'b10 : 2'b01;
      if (i % 17 == 0) begin
        e.h1 = e.h1 - ((i < 68) ? 4'd2 : 4'd1);
        e.h2 = e.h2 - ((i < 68) ? 4'd2 : 4'd1);
        e.s1 = 1'b1; e.s2 = 1'b1; e.t1 = f; e.t2 = f;
      end
      if (i == 85) begin
        e.gs = 2'b01; e.win = 2'b11; e.frz = 1'b1;
      end
      step(1, f, f, 0, 0, "draw_run_tick");
      e.s1 = 1'b0; e.s2 = 1'b0;
      step(0, f, f, 0, 0, "draw_run_gap");
    end

    // 70 KO ticks leave the counter at 50; reset with a would-be hit pending.
    for (int k = 0; k < 70; k++) step(1, 2'b01, 2'b01, 0, 0, "draw_ko_tick");
    reset_exp();
    step(1, 2'b01, 2'b01, 0, 1, "rst_in_ko");

    // Invulnerability cleared by reset: an immediate hit lands.
    e.h1 = 4'd9; e.s1 = 1'b1; e.t1 = 2'b01;
    step(1, 2'b01, 2'b00, 0, 0, "hit_after_rst");
    e.s1 = 1'b0;
    step(0, 2'b00, 2'b00, 0, 0, "hit_after_rst_gap");

    repeat (3) @(negedge clk);
    done = 1'b1;
  end

  // Monitor: compare every queued snapshot in the cycle it falls due.
  initial begin
    snap_t a, x;
    int    d;
    string nm;
    logic  stop;
    stop = 1'b0;
    while (!stop) begin
      @(negedge clk);
      a = '{h1: p1_health, h2: p2_health, s1: p1_stun_req, s2: p2_stun_req,
            t1: p1_stun_type, t2: p2_stun_type, gs: game_state, win: winner, frz: freeze};
      while (due_q.size() > 0 && due_q[0] <= cyc) begin
        d  = due_q.pop_front();
        x  = exp_q.pop_front();
        nm = name_q.pop_front();
        checks++;
        if (a !== x || d != cyc) begin
          errors++;
          $display("FAIL %s cyc=%0d due=%0d: got h=%0d/%0d stun=%b%b type=%b/%b state=%b win=%b frz=%b, want h=%0d/%0d stun=%b%b type=%b/%b state=%b win=%b frz=%b",
                   nm, cyc, d, a.h1, a.h2, a.s1, a.s2, a.t1, a.t2, a.gs, a.win, a.frz,
                   x.h1, x.h2, x.s1, x.s2, x.t1, x.t2, x.gs, x.win, x.frz);
        end
      end
      if (done) stop = 1'b1;
      if (cyc > 20000) begin
        checks++;
        errors++;
        $display("FAIL watchdog: got cyc=%0d, want stimulus done before 20000", cyc);
        stop = 1'b1;
      end
    end
    if (due_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL leftover: got %0d unchecked snapshots, want 0", due_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/hit_damage_tracker.md
# hit_damage_tracker

Downstream consumer of the per-player hit flags produced by the hit detector. It samples `p1_hit_flag`/`p2_hit_flag` once per video frame and applies damage to per-player health registers. It enforces post-hit invulnerability windows, emits one-clock stun requests to the player state machines, and runs the round state machine (play, KO hold, game over, new round). All outputs are registered.

## Interface
Parameters:
- `HEALTH_MAX`, 10: starting health; 1..15.
- `BASIC_DMG`, 1: damage for hit type 01.
- `DIR_DMG`, 2: damage for hit type 10.
- `INVULN_FRAMES`, 16: frames a player ignores hits after an accepted hit; 1..63.
- `KO_HOLD_FRAMES`, 120: frames spent in KO before game over; 1..255.

Ports:
- `clk`  in  1  system clock; one clock domain.
- `rst`  in  1  reset; synchronous and active-high.
- `frame_tick`  in  1  one-clock pulse per frame; the only sample point for hit flags.
- `p1_hit_flag`  in  2  hit flag for P1: 00 none, 01 basic, 10 directional, 11 ignored.
- `p2_hit_flag`  in  2  hit flag for P2, same encoding.
- `new_round`  in  1  restart request; honoured only in OVER.
- `p1_health`, `p2_health`  out  4  current health.
- `p1_stun_req`, `p2_stun_req`  out  1  one-clock pulse when a hit on that player is accepted.
- `p1_stun_type`, `p2_stun_type`  out  2  type of the last accepted hit; held until the next accepted hit.
- `game_state`  out  2  00 PLAY, 01 KO, 10 OVER.
- `winner`  out  2  00 none, 01 P1, 10 P2, 11 draw.
- `freeze`  out  1  high in KO and OVER; player movement gating.

## Operation
Reset, on any clock with `rst` high, takes priority over everything:
- health = `HEALTH_MAX`; both invuln counters = 0; KO counter = 0.
- state = PLAY; winner = 00; freeze = 0.
- stun pulses = 0; stun types = 00.

Hit acceptance, per player, evaluated only on a `frame_tick` clock:
- All conditions required: state = PLAY, flag is 01 or 10, that player's invuln counter = 0.
- On accept:
  - health ← max(health − dmg, 0), saturating with no wrap; dmg is `BASIC_DMG` or `DIR_DMG`.
  - invuln ← `INVULN_FRAMES`.
  - stun_req pulses.
  - stun_type ← flag.
- On reject with a nonzero invuln counter: the counter decrements by 1.
- Flag 11 is never accepted. The invuln counter still decrements.
- P1 and P2 are evaluated independently in the same clock. Simultaneous hits are both applied.

KO entry is decided from post-damage health in the same clock:
- Only P1 health reaches 0: winner = 10 (P2 wins).
- Only P2 health reaches 0: winner = 01 (P1 wins).
- Both reach 0: winner = 11 (draw).
- On entry: state ← KO, freeze ← 1, KO counter ← `KO_HOLD_FRAMES`.

State machine:
- KO: on each `frame_tick`, if KO counter = 1 then state ← OVER; otherwise decrement. Hit flags are ignored.
- OVER: holds indefinitely. `new_round` (level, sampled every clock, not tied to `frame_tick`) does the following:
  - health ← `HEALTH_MAX`; invuln counters ← 0.
  - winner ← 00; stun types ← 00; freeze ← 0; state ← PLAY.
- `new_round` has no effect in PLAY or KO.
- Invuln counters keep decrementing on `frame_tick` in KO and OVER.

## Timing
- Clocks without `frame_tick` change nothing except `new_round` handling in OVER.
- On the `frame_tick` clock edge N, the following all update on edge N, visible the cycle after the tick:
  - health, stun_type, invuln load, game_state, winner, freeze.
- stun_req is high exactly one clock, the cycle after edge N. It is never high on two consecutive clocks.
- Invulnerability with the flag held continuously: hit accepted at tick T, rejected at ticks T+1..T+`INVULN_FRAMES`, accepted again at T+`INVULN_FRAMES`+1.
- KO entered at tick T: OVER is visible after tick T+`KO_HOLD_FRAMES`.
- `rst` asserted mid-KO or mid-invulnerability: the next cycle shows reset values; no pending stun pulse is emitted.
- Killing hit: the stun pulse for that hit still fires in the same cycle as KO entry.

## Test plan
- Reset, then P2 flag 01 on one tick → p2_health 10→9, p2_stun_req high one clock, p2_stun_type 01, p1 outputs unchanged.
- P1 flag 10 held for 40 ticks (INVULN 16) → accepted at ticks 0, 17, 34 → p1_health 10→8→6→4, exactly three stun pulses.
- Flag 01 or 10 with no `frame_tick` for 100 clocks → no change; flag 11 on ticks → no damage, no stun.
- Both health 1 with BASIC_DMG 1, both flags 01 on the same tick → both health 0, winner 11, game_state 01, freeze 1, both stun pulses; OVER appears 120 ticks later.
- P2 health 1, P2 hit by 10 → p2_health 0 with no wrap, winner 01; in KO, `new_round` and further hit flags are ignored; in OVER, `new_round` → health 10/10, state 00, winner 00, freeze 0.
- `rst` pulsed during KO with counter 50 → next cycle state 00, health 10/10, winner 00, no stun pulses.
